// File: rtl/vga_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module : vga_sync_ctrl
// Brief  : VGA raster timing, coordinate/rgb pipeline and pattern selection.
//          Optional macro AUTO_CYCLE_EN adds timed pattern rotation.
// Rev    : 1.0  initial release
// ============================================================================
module vga_sync_ctrl #(
    parameter int   CLK_DIV  = 2,
    parameter int   H_ACT    = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYN    = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACT    = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYN    = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   NUM_PAT  = 4
`ifdef AUTO_CYCLE_EN
    ,
    parameter int   FRAMES_PER_PAT = 120
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       next_i,
    input  logic [2:0] rgb_i,
    output logic [8:0] row_o,
    output logic [9:0] column_o,
    output logic [1:0] pat_sel_o,
    output logic [2:0] rgb_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       frame_o
);
    localparam int               c_div_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
    localparam logic [9:0]       c_h_act    = 10'(H_ACT);
    localparam logic [9:0]       c_v_act    = 10'(V_ACT);
    localparam logic [9:0]       c_h_last   = 10'(H_ACT + H_FP + H_SYN + H_BP - 1);
    localparam logic [9:0]       c_v_last   = 10'(V_ACT + V_FP + V_SYN + V_BP - 1);
    localparam logic [9:0]       c_hs_first = 10'(H_ACT + H_FP);
    localparam logic [9:0]       c_hs_last  = 10'(H_ACT + H_FP + H_SYN - 1);
    localparam logic [9:0]       c_vs_first = 10'(V_ACT + V_FP);
    localparam logic [9:0]       c_vs_last  = 10'(V_ACT + V_FP + V_SYN - 1);
    localparam logic [1:0]       c_pat_last = 2'(NUM_PAT - 1);

    logic [c_div_w-1:0] r_div;
    logic [9:0]         r_h_cnt;
    logic [9:0]         r_v_cnt;
    logic [9:0]         r_h_d;
    logic [9:0]         r_v_d;
    logic               r_act_d;
    logic [8:0]         r_row;
    logic [9:0]         r_col;
    logic [2:0]         r_rgb;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_pending;
    logic [1:0]         r_pat;
    logic               r_frame;

    logic w_pix_en;
    logic w_h_wrap;
    logic w_frame_start;
    logic w_active;
    logic w_hs_on;
    logic w_vs_on;
    logic w_advance;

    assign w_pix_en      = (r_div == c_div_last);
    assign w_h_wrap      = (r_h_cnt == c_h_last);
    assign w_frame_start = w_pix_en && w_h_wrap && (r_v_cnt == c_v_last);
    assign w_active      = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    assign w_hs_on       = (r_h_d >= c_hs_first) && (r_h_d <= c_hs_last);
    assign w_vs_on       = (r_v_d >= c_vs_first) && (r_v_d <= c_vs_last);

    // Stage 0 registers coordinates; stage 1 registers rgb and syncs from the
    // delayed counters so the pins stay aligned with the generator output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div   <= '0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_h_d   <= '0;
            r_v_d   <= '0;
            r_act_d <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_rgb   <= '0;
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
        end else begin
            r_div <= w_pix_en ? '0 : r_div + 1'b1;
            if (w_pix_en) begin
                r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 10'd1;
                if (w_h_wrap) begin
                    r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + 10'd1;
                end
                r_row   <= w_active ? r_v_cnt[8:0] : '0;
                r_col   <= w_active ? r_h_cnt : '0;
                r_act_d <= w_active;
                r_h_d   <= r_h_cnt;
                r_v_d   <= r_v_cnt;
                r_rgb   <= r_act_d ? rgb_i : 3'b000;
                r_hsync <= w_hs_on ? SYNC_POL : ~SYNC_POL;
                r_vsync <= w_vs_on ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

`ifdef AUTO_CYCLE_EN
    localparam logic [6:0] c_fpp_last = 7'(FRAMES_PER_PAT - 1);
    logic [6:0] r_frame_cnt;

    // Any advance, manual or timed, restarts the per-pattern frame count.
    assign w_advance = r_pending || next_i || (r_frame_cnt == c_fpp_last);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_frame_cnt <= '0;
        end else if (w_frame_start) begin
            r_frame_cnt <= w_advance ? '0 : r_frame_cnt + 7'd1;
        end
    end
`else
    assign w_advance = r_pending || next_i;
`endif

    // Requests are held until the frame boundary so the pattern never
    // switches mid-frame; a pulse on the boundary edge itself still counts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending <= 1'b0;
            r_pat     <= '0;
            r_frame   <= 1'b0;
        end else begin
            r_frame <= w_frame_start;
            if (w_frame_start) begin
                r_pending <= 1'b0;
                if (w_advance) begin
                    r_pat <= (r_pat == c_pat_last) ? '0 : r_pat + 2'd1;
                end
            end else if (next_i) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign row_o     = r_row;
    assign column_o  = r_col;
    assign pat_sel_o = r_pat;
    assign rgb_o     = r_rgb;
    assign hsync_o   = r_hsync;
    assign vsync_o   = r_vsync;
    assign frame_o   = r_frame;

endmodule
`default_nettype wire
